// File: rtl/serial_transmitter_pkg.sv
// Shared definitions for the serial transmitter: frame geometry, FSM state
// encoding and the helper that turns a queued FIFO entry into the 8-bit
// payload ({parity, data}) shifted out after the start bit.
package serial_transmitter_pkg;

    localparam int FRAME_DATA_BITS = 7;
    localparam int FRAME_BITS      = 8;   // data bits plus parity bit

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Parity is even over the 8 payload bits; parity_err flips it so a
    // receiver's parity check can be exercised.
    function automatic logic [FRAME_BITS-1:0] make_payload(
        input logic [FRAME_DATA_BITS-1:0] data,
        input logic                       parity_err
    );
        return {(^data) ^ parity_err, data};
    endfunction

endpackage

// File: rtl/serial_transmitter_tx_fifo.sv
// tx_fifo: circular-buffer FIFO holding characters waiting to be framed.
//   clk, rstn   : clock, asynchronous active-low reset (pointers/count only)
//   push        : write push_data when not full (ignored when full)
//   push_data   : entry to store
//   pop         : drop the head entry when not empty
//   head        : current head entry (valid while count != 0)
//   count       : number of stored entries, 0..DEPTH
//   not_full    : count != DEPTH, from registered state only
module tx_fifo
    import serial_transmitter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = FRAME_BITS
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           not_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign not_full = (count != FULL_CNT);
    assign do_push  = push && not_full;
    assign do_pop   = pop && (count != '0);
    assign head     = mem[rd_ptr];

    // Storage carries no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_transmitter.sv
// serial_transmitter: queues 7-bit characters and sends each as a 10-bit
// frame (start 0, data LSB first, parity, stop 1), one bit per clock.
//   clk, rstn     : clock, asynchronous active-low reset
//   in_valid      : producer offers in_data / in_parity_err
//   in_data       : 7-bit character, bit 0 sent first
//   in_parity_err : invert this character's parity bit
//   in_ready      : FIFO can accept a character this cycle
//   serial_out    : registered serial line, idle high
//   busy          : FSM not idle
//   frame_done    : one-cycle pulse during the stop bit
//   fifo_count    : characters waiting in the FIFO
module serial_transmitter
    import serial_transmitter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                in_valid,
    input  logic [FRAME_DATA_BITS-1:0]          in_data,
    input  logic                                in_parity_err,
    output logic                                in_ready,
    output logic                                serial_out,
    output logic                                busy,
    output logic                                frame_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);

    localparam int BC_W = $clog2(FRAME_BITS);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(FRAME_BITS - 1);

    tx_state_t             state;
    logic [FRAME_BITS-1:0] head;
    logic [FRAME_BITS-1:0] shreg;
    logic [BC_W-1:0]       bit_cnt;
    logic                  pop;

    // The line is free for a new frame while idle or during a stop bit,
    // which lets frames stream with a single stop cycle between them.
    assign pop  = ((state == ST_IDLE) || (state == ST_STOP)) && (fifo_count != '0);
    assign busy = (state != ST_IDLE);

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FRAME_BITS)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (in_valid),
        .push_data ({in_parity_err, in_data}),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .not_full  (in_ready)
    );

    // Payload register: loaded on pop, shifted while its bits go out.
    always_ff @(posedge clk) begin
        if (pop) begin
            shreg <= make_payload(head[FRAME_DATA_BITS-1:0], head[FRAME_DATA_BITS]);
        end else if ((state == ST_START) || (state == ST_DATA)) begin
            shreg <= shreg >> 1;
        end
    end

    // serial_out is updated on the same edge as the state, so the line
    // always shows the bit belonging to the current state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            serial_out <= 1'b1;
            frame_done <= 1'b0;
            bit_cnt    <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state      <= ST_START;
                        serial_out <= 1'b0;
                    end else begin
                        serial_out <= 1'b1;
                    end
                end
                ST_START: begin
                    state      <= ST_DATA;
                    serial_out <= shreg[0];
                    bit_cnt    <= '0;
                end
                ST_DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        state      <= ST_STOP;
                        serial_out <= 1'b1;
                        frame_done <= 1'b1;
                    end else begin
                        serial_out <= shreg[0];
                        bit_cnt    <= bit_cnt + BC_W'(1);
                    end
                end
                ST_STOP: begin
                    if (pop) begin
                        state      <= ST_START;
                        serial_out <= 1'b0;
                    end else begin
                        state      <= ST_IDLE;
                        serial_out <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    serial_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_transmitter.sv
// Bench for serial_transmitter: fixed frame table, hand-written multi-cycle
// sequences and a random phase, all against a frame-level reference model.
module tb_serial_transmitter;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_valid = 1'b0;
    logic [6:0]    in_data = 7'd0;
    logic          in_parity_err = 1'b0;
    logic          in_ready;
    logic          serial_out;
    logic          busy;
    logic          frame_done;
    logic [CW-1:0] fifo_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_transmitter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_parity_err (in_parity_err),
        .in_ready      (in_ready),
        .serial_out    (serial_out),
        .busy          (busy),
        .frame_done    (frame_done),
        .fifo_count    (fifo_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of waiting characters and the position
    // (0..9, or -1 for idle line) inside the frame currently on the line.
    logic [7:0] m_pend [$];
    int         m_pos = -1;
    logic [9:0] m_bits = '1;
    int         m_acc = 0;
    logic       m_take;
    logic [7:0] m_char;

    // Downstream receiver decoding the actual line: {parity_ok_n, data}.
    logic [7:0] rx_q [$];
    int         rx_pos = -1;
    logic [7:0] rx_sh = '0;
    int         fd_cnt = 0;

    function automatic logic [9:0] frame_of(input logic [7:0] c);
        logic [9:0] b;
        b[0] = 1'b0;
        for (int i = 0; i < 7; i++) b[i+1] = c[i];
        b[8] = (^c[6:0]) ^ c[7];
        b[9] = 1'b1;
        return b;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_pend.delete();
            m_pos  = -1;
            rx_pos = -1;
            #1;
            chk("rst_serial_out", serial_out, 1);
            chk("rst_busy", busy, 0);
            chk("rst_frame_done", frame_done, 0);
            chk("rst_fifo_count", fifo_count, 0);
            chk("rst_in_ready", in_ready, 1);
        end else begin
            m_take = in_valid && (m_pend.size() < DEPTH);
            m_char = {in_parity_err, in_data};
            if (m_pos == -1 || m_pos == 9) begin
                if (m_pend.size() > 0) begin
                    m_bits = frame_of(m_pend.pop_front());
                    m_pos  = 0;
                end else begin
                    m_pos = -1;
                end
            end else begin
                m_pos++;
            end
            if (m_take) begin
                m_pend.push_back(m_char);
                m_acc++;
            end
            #1;
            chk("line", serial_out, (m_pos == -1) ? 1'b1 : m_bits[m_pos]);
            chk("frame_done", frame_done, m_pos == 9);
            chk("busy", busy, m_pos != -1);
            chk("fifo_count", fifo_count, m_pend.size());
            chk("in_ready", in_ready, m_pend.size() != DEPTH);
            if (frame_done) fd_cnt++;
            if (rx_pos == -1) begin
                if (serial_out == 1'b0) rx_pos = 0;
            end else begin
                rx_pos++;
                if (rx_pos <= 8) begin
                    rx_sh[rx_pos-1] = serial_out;
                end else begin
                    chk("rx_stop", serial_out, 1);
                    rx_q.push_back({^rx_sh, rx_sh[6:0]});
                    rx_pos = -1;
                end
            end
        end
    end

    typedef struct {
        logic [6:0] data;
        logic       perr;
        logic [9:0] line;   // bit i = expected line value i cycles after E+1
        logic       pok_n;
    } vec_t;

    initial begin
        vec_t tbl [6];
        int   n;
        int   fd0;
        tbl[0] = '{7'h55, 1'b0, 10'b1010101010, 1'b0};
        tbl[1] = '{7'h07, 1'b1, 10'b1000001110, 1'b1};
        tbl[2] = '{7'h00, 1'b0, 10'b1000000000, 1'b0};
        tbl[3] = '{7'h7F, 1'b0, 10'b1111111110, 1'b0};
        tbl[4] = '{7'h7F, 1'b1, 10'b1011111110, 1'b1};
        tbl[5] = '{7'h01, 1'b0, 10'b1100000010, 1'b0};

        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Single frames from idle: exact bit timing and receiver result.
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_data = tbl[k].data; in_parity_err = tbl[k].perr;
            @(negedge clk);
            in_valid = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                chk($sformatf("vec%0d_bit%0d", k, i), serial_out, tbl[k].line[i]);
                chk($sformatf("vec%0d_fd%0d", k, i), frame_done, i == 9);
            end
            @(posedge clk); #1;
            chk($sformatf("vec%0d_idle", k), busy, 0);
            chk($sformatf("vec%0d_rx", k), (rx_q.size() > 0) ? rx_q[$] : 8'hxx,
                {tbl[k].pok_n, 1'b0, tbl[k].data} & 8'hFF | {tbl[k].pok_n, tbl[k].data});
            @(negedge clk);
        end

        // Five consecutive pushes fill the FIFO; 0x7F then waits for space.
        rx_q.delete();
        in_valid = 1'b1; in_parity_err = 1'b0;
        for (int v = 0; v < 5; v++) begin
            in_data = 7'(v);
            @(negedge clk);
        end
        chk("full_count", fifo_count, 4);
        chk("full_ready", in_ready, 0);
        in_data = 7'h7F;
        n = 0;
        fd0 = m_acc;
        while (n < 100 && m_acc == fd0) begin
            @(negedge clk);
            n++;
        end
        chk("hold_cycles_until_accept", n, 8);
        in_valid = 1'b0;
        repeat (70) @(negedge clk);
        chk("stream_rx_count", rx_q.size(), 6);
        for (int v = 0; v < 6; v++) begin
            chk($sformatf("stream_rx%0d", v), (rx_q.size() > v) ? rx_q[v] : 8'hxx,
                (v == 5) ? 8'h7F : 8'(v));
        end

        // Reset during data bit 3 with two characters queued.
        in_valid = 1'b1;
        in_data = 7'h11; @(negedge clk);
        in_data = 7'h22; @(negedge clk);
        in_data = 7'h33; @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (n < 50 && m_pos != 4) begin
            @(negedge clk);
            n++;
        end
        chk("wait_data_bit3", m_pos, 4);
        chk("pre_rst_count", fifo_count, 2);
        rstn = 1'b0;
        #1;
        chk("midframe_rst_line", serial_out, 1);
        chk("midframe_rst_count", fifo_count, 0);
        fd0 = fd_cnt;
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        repeat (30) @(negedge clk);
        chk("no_frame_after_rst", fd_cnt - fd0, 0);
        rx_q.delete();
        in_valid = 1'b1; in_data = 7'h2A;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (14) @(negedge clk);
        chk("post_rst_rx", (rx_q.size() == 1) ? rx_q[0] : 8'hxx, 8'h2A);

        // Push coinciding with the stop-bit pop while one character waits.
        rx_q.delete();
        in_valid = 1'b1;
        in_data = 7'h41; @(negedge clk);
        in_data = 7'h42; @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (n < 50 && m_pos != 9) begin
            @(negedge clk);
            n++;
        end
        chk("wait_stop", m_pos, 9);
        in_valid = 1'b1; in_data = 7'h43;
        @(posedge clk); #1;
        chk("stop_push_count", fifo_count, 1);
        chk("stop_push_start", serial_out, 0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (30) @(negedge clk);
        chk("stop_push_rx_count", rx_q.size(), 3);
        for (int v = 0; v < 3; v++) begin
            chk($sformatf("stop_push_rx%0d", v), (rx_q.size() > v) ? rx_q[v] : 8'hxx,
                8'(8'h41 + v));
        end

        // Random traffic with one reset in the middle.
        for (int c = 0; c < 600; c++) begin
            in_valid      = ($urandom_range(0, 2) != 0);
            in_data       = 7'($urandom);
            in_parity_err = ($urandom_range(0, 7) == 0);
            if (c == 300) rstn = 1'b0;
            if (c == 302) rstn = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (60) @(negedge clk);
        chk("drain_count", fifo_count, 0);
        chk("drain_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_transmitter.md
SERIAL_TRANSMITTER -- requirements
Module: serial_transmitter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning number of queued characters (power of two, >=2).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  producer offers a character.
REQ-005 SHALL have port in_data  input  7  character, bit 0 sent first.
REQ-006 SHALL have port in_parity_err  input  1  invert the parity bit of this character (test aid).
REQ-007 SHALL have port in_ready  output  1  FIFO can accept.
REQ-008 SHALL have port serial_out  output  1  serial line, idle high.
REQ-009 SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse, coincident with the stop bit.
REQ-011 SHALL have port fifo_count  output  clog2(FIFO_DEPTH+1)  queued characters.

Function
REQ-012 SHALL accept a character on a rising edge with in_valid && in_ready; in_ready = (fifo_count != FIFO_DEPTH), derived from registered state only.
REQ-013 SHALL ignore in_valid while in_ready is low; no overwrite, no count change.
REQ-014 SHALL store {in_parity_err, in_data} per FIFO entry; circular pointers wrap at FIFO_DEPTH.
REQ-015 SHALL, on simultaneous push and pop, keep fifo_count unchanged and preserve order.
REQ-016 SHALL frame each character as 10 one-clock bits: start 0; data[0]..data[6]; parity P = ^data XOR parity_err (even over 8 bits when no error); stop 1.
REQ-017 SHALL drive serial_out from a register; FSM states IDLE, START, DATA, STOP.
REQ-018 IDLE: serial_out=1; if fifo_count>0 pop head into an 8-bit shift register {P,data} and go START on the next edge.
REQ-019 START: serial_out=0 for one cycle, then DATA with bit counter 0.
REQ-020 DATA: serial_out = shift register bit 0, shift right each cycle; leave for STOP after counter 7 (8 cycles).
REQ-021 STOP: serial_out=1, frame_done=1 for one cycle; if fifo_count>0 pop and go START directly, else IDLE.
REQ-022 Latency: character accepted into empty FIFO at edge E with FSM idle -> start bit from edge E+1, stop bit from edge E+10.
REQ-023 Back-to-back characters SHALL stream with exactly one stop cycle between frames (period 10 clocks).
REQ-024 A pop in IDLE/STOP SHALL occur in the same edge as a push when both are requested.

Reset
REQ-025 rstn low SHALL immediately force serial_out=1, busy=0, frame_done=0, fifo_count=0, in_ready=1, FSM=IDLE, pointers and bit counter 0.
REQ-026 Reset mid-frame SHALL abort the frame and discard all queued characters; first frame after release starts only after a new accept.

Structure
REQ-027 Shared package SHALL hold FSM state encoding, FRAME_DATA_BITS=7, FRAME_BITS=8 (data+parity).
REQ-028 FIFO SHALL be a sub-module tx_fifo (width 8, depth FIFO_DEPTH, push/pop/count); FSM and shift register in serial_transmitter.

Verification
REQ-029 Push 0x55, no error -> serial_out 0,1,0,1,0,1,0,1,0,1 from E+1; frame_done at E+10; downstream receiver data_out=0x55, parity_ok_n=0.
REQ-030 Push 0x07 with in_parity_err=1 -> parity bit 0 (instead of 1); receiver parity_ok_n=1, data_out=0x07.
REQ-031 Push 0x01,0x02,0x03,0x04 on consecutive cycles while first frame queued -> in_ready low when count=4, four contiguous frames in 40 cycles, receiver outputs in order.
REQ-032 Hold in_valid with 0x7F while full -> no count change, 0x7F accepted only when in_ready returns high after a pop.
REQ-033 Assert rstn low during DATA bit 3 with 2 characters queued -> serial_out=1 immediately, fifo_count=0; no frame_done until a new push.
REQ-034 Push on the same edge a STOP-state pop occurs with count=1 -> count stays 1, next start bit immediately after stop.
